// File: rtl/bumpy_motion_ctrl.sv
// Character motion controller: frame-rate X/Y update with jump/fall FSM,
// edge-collision flags accumulated between frame pulses.
module bumpy_motion_ctrl #(
   parameter int INITIAL_X  = 280,
   parameter int INITIAL_Y  = 185,
   parameter int JUMP_SPEED = 12,
   parameter int GRAVITY    = 1,
   parameter int MAX_FALL   = 12,
   parameter int X_SPEED    = 2,
   parameter int X_MAX      = 607,
   parameter int FLOOR_Y    = 447
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        moveLeft,
   input  logic        moveRight,
   input  logic        jumpKey,
   input  logic        collision,
   input  logic [3:0]  HitEdgeCode,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      StGrounded = 2'd0,
      StRising   = 2'd1,
      StFalling  = 2'd2,
      StBad      = 2'd3
   } st_e;

   localparam logic signed [11:0] XSpd    = 12'(X_SPEED);
   localparam logic signed [11:0] XMax    = 12'(X_MAX);
   localparam logic signed [11:0] FloorY  = 12'(FLOOR_Y);
   localparam logic signed [11:0] Grav    = 12'(GRAVITY);
   localparam logic signed [11:0] MaxFall = 12'(MAX_FALL);
   localparam logic signed [7:0]  JumpVy  = 8'(-JUMP_SPEED);
   localparam logic [10:0]        InitX   = 11'(INITIAL_X);
   localparam logic [10:0]        InitY   = 11'(INITIAL_Y);
   localparam logic [10:0]        FloorPos = 11'(FLOOR_Y);

   st_e               st_q;
   logic signed [7:0] vy_q;
   logic              hit_l_q, hit_t_q, hit_r_q, hit_b_q;

   // {L,T,R,B}: sticky flags plus a collision arriving on the frame cycle itself
   logic [3:0]         hit_now;
   logic signed [11:0] x_cur, x_step, y_cur, y_sum, vy_ext, vy_inc;
   logic [10:0]        x_next, y_step;
   logic signed [7:0]  vy_fall;

   assign state = st_q;

   // Next-position arithmetic, done in 12-bit signed so nothing wraps before clamping
   always_comb begin
      hit_now = {hit_l_q, hit_t_q, hit_r_q, hit_b_q} | ({4{collision}} & HitEdgeCode);
      x_cur   = signed'({1'b0, topLeftX});
      y_cur   = signed'({1'b0, topLeftY});
      vy_ext  = {{4{vy_q[7]}}, vy_q};
      x_step  = x_cur;
      if (moveRight && !moveLeft && !hit_now[1]) begin
         x_step = x_cur + XSpd;
      end else if (moveLeft && !moveRight && !hit_now[3]) begin
         x_step = x_cur - XSpd;
      end
      if (x_step < 12'sd0) begin
         x_next = 11'd0;
      end else if (x_step > XMax) begin
         x_next = XMax[10:0];
      end else begin
         x_next = x_step[10:0];
      end
      y_sum  = y_cur + vy_ext;
      y_step = (y_sum < 12'sd0) ? 11'd0 : y_sum[10:0];
      vy_inc = vy_ext + Grav;
      vy_fall = (vy_inc > MaxFall) ? MaxFall[7:0] : vy_inc[7:0];
   end

   // Motion FSM: flags accumulate between frames, everything else moves on startOfFrame
   always_ff @(posedge clk) begin
      if (!resetN) begin
         topLeftX <= InitX;
         topLeftY <= InitY;
         vy_q     <= 8'sd0;
         st_q     <= StFalling;
         hit_l_q  <= 1'b0;
         hit_t_q  <= 1'b0;
         hit_r_q  <= 1'b0;
         hit_b_q  <= 1'b0;
      end else if (startOfFrame) begin
         hit_l_q  <= 1'b0;
         hit_t_q  <= 1'b0;
         hit_r_q  <= 1'b0;
         hit_b_q  <= 1'b0;
         topLeftX <= x_next;
         case (st_q)
            StGrounded: begin
               if (jumpKey) begin
                  vy_q <= JumpVy;
                  st_q <= StRising;
               end else if (y_cur < FloorY && !hit_now[0]) begin
                  vy_q <= 8'sd0;
                  st_q <= StFalling;
               end
            end
            StRising: begin
               topLeftY <= y_step;
               if (vy_inc >= 12'sd0 || hit_now[2]) begin
                  vy_q <= 8'sd0;
                  st_q <= StFalling;
               end else begin
                  vy_q <= vy_inc[7:0];
               end
            end
            StFalling: begin
               // Landing on an obstacle wins over the floor clamp
               if (hit_now[0]) begin
                  vy_q <= JumpVy;
                  st_q <= StRising;
               end else if (y_sum >= FloorY) begin
                  topLeftY <= FloorPos;
                  vy_q     <= 8'sd0;
                  st_q     <= StGrounded;
               end else begin
                  topLeftY <= y_step;
                  vy_q     <= vy_fall;
               end
            end
            default: begin
               vy_q <= 8'sd0;
               st_q <= StFalling;
            end
         endcase
      end else if (collision) begin
         hit_l_q <= hit_l_q | HitEdgeCode[3];
         hit_t_q <= hit_t_q | HitEdgeCode[2];
         hit_r_q <= hit_r_q | HitEdgeCode[1];
         hit_b_q <= hit_b_q | HitEdgeCode[0];
      end
   end

endmodule

// File: tb/tb_bumpy_motion_ctrl.sv
// Directed bench for bumpy_motion_ctrl with hand-computed positions.
module tb_bumpy_motion_ctrl;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        moveLeft = 1'b0;
   logic        moveRight = 1'b0;
   logic        jumpKey = 1'b0;
   logic        collision = 1'b0;
   logic [3:0]  HitEdgeCode = 4'd0;
   logic [10:0] topLeftX, topLeftY;
   logic [1:0]  state;

   int total = 0;
   int bad = 0;

   bumpy_motion_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .moveLeft     (moveLeft),
      .moveRight    (moveRight),
      .jumpKey      (jumpKey),
      .collision    (collision),
      .HitEdgeCode  (HitEdgeCode),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int ex, input int ey, input int es);
      chk({tag, "_x"}, int'(topLeftX), ex);
      chk({tag, "_y"}, int'(topLeftY), ey);
      chk({tag, "_st"}, int'(state), es);
   endtask

   task automatic frame();
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic hit_pulse(input logic [3:0] code);
      @(negedge clk);
      collision   = 1'b1;
      HitEdgeCode = code;
      @(negedge clk);
      collision   = 1'b0;
      HitEdgeCode = 4'd0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk_pos("reset", 280, 185, 2);
      resetN = 1'b1;

      // Free fall from reset: Y steps 0,1,2,... capped at 12
      frame(); chk("fall1_y", int'(topLeftY), 185);
      frame(); chk("fall2_y", int'(topLeftY), 186);
      frame(); chk("fall3_y", int'(topLeftY), 188);
      frame(); chk("fall4_y", int'(topLeftY), 191);
      frames(8);  chk_pos("fall12", 280, 251, 2);
      frames(16); chk_pos("fall28", 280, 443, 2);
      frame();    chk_pos("land29", 280, 447, 0);
      frames(11); chk_pos("ground40", 280, 447, 0);

      // Jump from the floor
      jumpKey = 1'b1;
      frame();
      jumpKey = 1'b0;
      chk_pos("jump0", 280, 447, 1);
      frame();    chk_pos("jump1", 280, 435, 1);
      frames(10); chk_pos("jump11", 280, 370, 1);
      frame();    chk_pos("apex", 280, 369, 2);

      // Falling, bottom hit mid-frame triggers bounce
      frame(); chk("fallb1_y", int'(topLeftY), 369);
      frame(); chk("fallb2_y", int'(topLeftY), 370);
      hit_pulse(4'b0001);
      frame(); chk_pos("bounce", 280, 370, 1);
      frame(); chk_pos("bounce1", 280, 358, 1);
      frame(); chk_pos("bounce2", 280, 347, 1);

      // Top hit coincident with the frame pulse while rising
      @(negedge clk);
      startOfFrame = 1'b1;
      collision    = 1'b1;
      HitEdgeCode  = 4'b0100;
      @(negedge clk);
      startOfFrame = 1'b0;
      collision    = 1'b0;
      HitEdgeCode  = 4'd0;
      chk_pos("tophit", 280, 337, 2);
      frame(); chk_pos("tophit1", 280, 337, 2);
      frame(); chk_pos("tophit2", 280, 338, 2);
      for (int i = 0; i < 60 && state != 2'd0; i++) frame();
      chk_pos("reland", 280, 447, 0);

      // Horizontal saturation at the right edge
      moveRight = 1'b1;
      frames(163); chk("right606", int'(topLeftX), 606);
      frame();     chk("right607a", int'(topLeftX), 607);
      frame();     chk("right607b", int'(topLeftX), 607);
      frame();     chk("right607c", int'(topLeftX), 607);
      moveRight = 1'b0;
      moveLeft  = 1'b1;
      frame();     chk("left605", int'(topLeftX), 605);
      moveLeft  = 1'b0;

      // Right-edge hit blocks one step, then the flag is gone
      hit_pulse(4'b0010);
      moveRight = 1'b1;
      frame(); chk("hitr_block", int'(topLeftX), 605);
      frame(); chk("hitr_clear", int'(topLeftX), 607);
      moveLeft = 1'b1;
      frame(); chk("both_keys", int'(topLeftX), 607);
      moveRight = 1'b0;

      // Left-edge saturation
      frames(303); chk("left1", int'(topLeftX), 1);
      frame();     chk("left0a", int'(topLeftX), 0);
      frame();     chk_pos("left0b", 0, 447, 0);
      moveLeft = 1'b0;

      // Reset during a jump, coincident with a frame pulse
      jumpKey = 1'b1;
      frame();
      jumpKey = 1'b0;
      frame(); chk_pos("prerst", 0, 435, 1);
      @(negedge clk);
      resetN       = 1'b0;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      chk_pos("midrst", 280, 185, 2);
      resetN = 1'b1;
      frame(); chk_pos("postrst1", 280, 185, 2);
      frame(); chk_pos("postrst2", 280, 186, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
